answer_collector: RTL
=====================

# answer_collector

Sequential front end for the quiz ranking datapath. Runs a four-question round and gathers one correct/incorrect bit per contestant per question over a valid/ready answer port. It assembles the 4-bit answer vectors `c1`..`c7` and the player count `n` that the combinational scoring/ranking block consumes. Outputs are registered and held stable while `valid` is high.

## Interface
- `TIMEOUT`, default 16: cycles a question stays open before it closes with unanswered contestants scored 0 (legal range 2..255).
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  begin a new round (sampled in IDLE and DONE only)
- `num_players`  in  4  active contestant count, sampled with `start`
- `ans_valid`  in  1  answer present
- `ans_id`  in  3  contestant number, 1..7
- `ans_bit`  in  1  1 = correct, 0 = wrong
- `ans_ready`  out  1  answer port open
- `err`  out  1  one-cycle pulse: a handshaked answer was rejected
- `q_idx`  out  2  current question, 0..3
- `busy`  out  1  round in progress
- `valid`  out  1  `c1`..`c7` and `n` complete and stable
- `n`  out  4  latched player count
- `c1`..`c7`  out  4 each  answer vectors; bit 3 = question 0, bit 0 = question 3

## Operation
- **Reset.** All outputs are 0. The FSM goes to IDLE, and the timer, mask and `q_idx` clear.
- **States.** IDLE, COLLECT, ADVANCE, DONE.
- **IDLE.** `ans_ready`=0, `busy`=0.
  - `start` with `num_players`≠0 latches `n` (values >7 clamp to 7), clears `c1`..`c7`, the answered mask and the timer, sets `q_idx`=0, and moves to COLLECT.
  - `start` with `num_players`=0 is ignored.
- **COLLECT.** `ans_ready`=1, `busy`=1.
  - **Accept.** An answer is accepted on `ans_valid`&`ans_ready` when 1≤`ans_id`≤`n` and the mask bit for `ans_id` is clear. Acceptance writes `c<ans_id>[3-q_idx]` <= `ans_bit` and sets the mask bit.
  - **Reject.** Any other handshake (id 0, id>`n`, duplicate) is dropped, the vectors are untouched, and `err`=1 the next cycle. For a duplicate, the first answer wins.
  - **Timer.** The timer increments every COLLECT cycle.
  - **Exit.** COLLECT exits to ADVANCE when the registered mask covers ids 1..`n`, or when timer = `TIMEOUT`-1.
  - **Same-cycle events.** If the final answer and the timeout coincide, the answer is accepted, then the question closes.
- **ADVANCE** (1 cycle). `ans_ready`=0. The mask and timer clear.
  - If `q_idx`=3, go to DONE and leave `q_idx` at 3.
  - Otherwise `q_idx`++ and go back to COLLECT.
- **DONE.** `valid`=1, `busy`=0, `ans_ready`=0. Vectors are held indefinitely. `start` behaves as in IDLE: `valid` drops on the same edge that clears the vectors.
- **Ignored inputs.** `start` during COLLECT/ADVANCE is ignored. `ans_valid` outside COLLECT is ignored and does not pulse `err`.
- **Reset mid-round.** Returns to IDLE with all outputs 0, and no partial vectors survive.

## Timing
- An answer accepted at edge k is visible on `c<id>` after edge k.
- The mask completes at edge k, so `ans_ready` falls after edge k+1 (the ADVANCE state).
- The next question opens (`ans_ready`=1, new `q_idx`) after edge k+2.
- **Question length.** Minimum = `n` accept cycles + 1 close cycle. Maximum = `TIMEOUT` COLLECT cycles. Each question adds 1 ADVANCE cycle.
- `valid` rises after the edge that leaves the last ADVANCE.
- `err` is asserted the cycle after the rejected handshake, for exactly 1 cycle.
- **Full-round minimum**, from `start` edge to `valid`: 4×(`n`+2) cycles.

## Test plan
- **Full round, all correct.** `rst`, start `num_players`=7, all 7 answer `ans_bit`=1 for each of the 4 questions → `c1`..`c7`=4'hF, `n`=7, `valid`=1 after 36 cycles.
- **Pattern check.** Start `num_players`=3. Per question q, id1 answers q even, id2 answers q≥2, id3 answers never correct → `c1`=4'b1010, `c2`=4'b0011, `c3`=4'b0000. Unused vectors `c4`..`c7`=0.
- **Timeout.** `TIMEOUT`=16, `num_players`=5, only id1 answers 1 each question → each question closes after 16 COLLECT cycles, `c1`=4'hF, `c2`..`c5`=0, `valid` after 68 cycles.
- **Rejections.** In q0 send id 0, id 6 with `n`=5, then id2 twice (1 then 0) → `err` pulses 3 times, and `c2[3]`=1.
- **Abort and restart.** `rst` asserted during q2 → all outputs 0 and IDLE next cycle. Restart with `num_players`=9 → `n`=7.
- **Ignored/edge starts.** `start` with `num_players`=0 in IDLE → stays IDLE. `start` during COLLECT → no effect. `start` in DONE → `valid` drops and a new round begins with the vectors cleared.

Source files
------------

// File: rtl/answer_collector.sv
`default_nettype none
// ============================================================================
// Module   : answer_collector
// Purpose  : Runs a four-question quiz round and builds one answer vector per
//            contestant, plus the latched player count, for the ranking block.
// Revision : 1.0  initial release
// ============================================================================
module answer_collector #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] num_players,
    input  logic       ans_valid,
    input  logic [2:0] ans_id,
    input  logic       ans_bit,
    output logic       ans_ready,
    output logic       err,
    output logic [1:0] q_idx,
    output logic       busy,
    output logic       valid,
    output logic [3:0] n,
    output logic [3:0] c1,
    output logic [3:0] c2,
    output logic [3:0] c3,
    output logic [3:0] c4,
    output logic [3:0] c5,
    output logic [3:0] c6,
    output logic [3:0] c7
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_collect = 2'd1;
    localparam logic [1:0] c_advance = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_n;
    logic [1:0] r_q_idx;
    logic [7:0] r_timer;
    logic [7:1] r_mask;
    logic       r_err;
    logic [3:0] r_c [1:7];

    logic [7:1] w_sel;
    logic [7:1] w_need;
    logic       w_start_ok;
    logic       w_hs;
    logic       w_in_range;
    logic       w_dup;
    logic       w_accept;
    logic       w_all;
    logic       w_close;
    logic [1:0] w_bitpos;
    logic [3:0] w_n_clamp;

    always_comb begin
        w_sel  = '0;
        w_need = '0;
        for (int i = 1; i <= 7; i++) begin
            w_sel[i]  = (ans_id == 3'(i));
            w_need[i] = (r_n >= 4'(i));
        end
    end

    assign w_start_ok = start && (num_players != 4'd0) &&
                        ((r_state == c_idle) || (r_state == c_done));
    assign w_hs       = ans_valid && (r_state == c_collect);
    assign w_in_range = (ans_id != 3'd0) && ({1'b0, ans_id} <= r_n);
    assign w_dup      = |(w_sel & r_mask);
    assign w_accept   = w_hs && w_in_range && !w_dup;
    // Completion is judged on the registered mask, so the last answer costs one close cycle.
    assign w_all      = ((r_mask & w_need) == w_need);
    assign w_close    = w_all || (r_timer == c_timer_last);
    assign w_bitpos   = 2'd3 - r_q_idx;
    assign w_n_clamp  = (num_players > 4'd7) ? 4'd7 : num_players;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle, c_done: if (w_start_ok) w_state_nxt = c_collect;
            c_collect:      if (w_close) w_state_nxt = c_advance;
            c_advance:      w_state_nxt = (r_q_idx == 2'd3) ? c_done : c_collect;
            default:        w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_q_idx <= '0;
            r_timer <= '0;
            r_mask  <= '0;
            r_err   <= 1'b0;
            for (int i = 1; i <= 7; i++) r_c[i] <= '0;
        end else begin
            r_err <= w_hs && !w_accept;
            if (w_start_ok) begin
                r_n     <= w_n_clamp;
                r_q_idx <= '0;
                r_timer <= '0;
                r_mask  <= '0;
                for (int i = 1; i <= 7; i++) r_c[i] <= '0;
            end else begin
                case (r_state)
                    c_collect: begin
                        r_timer <= r_timer + 8'd1;
                        if (w_accept) begin
                            r_mask <= r_mask | w_sel;
                            for (int i = 1; i <= 7; i++) begin
                                if (w_sel[i]) r_c[i][w_bitpos] <= ans_bit;
                            end
                        end
                    end
                    c_advance: begin
                        r_mask  <= '0;
                        r_timer <= '0;
                        if (r_q_idx != 2'd3) r_q_idx <= r_q_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ans_ready = (r_state == c_collect);
    assign busy      = (r_state == c_collect) || (r_state == c_advance);
    assign valid     = (r_state == c_done);
    assign err       = r_err;
    assign q_idx     = r_q_idx;
    assign n         = r_n;
    assign c1        = r_c[1];
    assign c2        = r_c[2];
    assign c3        = r_c[3];
    assign c4        = r_c[4];
    assign c5        = r_c[5];
    assign c6        = r_c[6];
    assign c7        = r_c[7];

endmodule
`default_nettype wire
